sipo_frame_deser: RTL and testbench

Serial-to-parallel frame deserializer that sits directly upstream of the team's 4-bit parallel-load register. It collects WIDTH serial bits into a frame delimited by a start flag, then presents the assembled word with a one-cycle load strobe. The output pair (data_out, load) connects directly to the register's data_in and load inputs.

---
 rtl/sipo_frame_deser.sv | 193 +++++++++++++++++++
 tb/tb_sipo_frame_deser.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_deser.sv
// ---------------------------------------------------------------------------
// sipo_frame_deser
//
// Serial-to-parallel frame deserializer. It collects WIDTH serial bits into a
// frame that begins with a start flag, then presents the assembled word on
// data_o together with a one-cycle load strobe. data_o/load_o feed the
// data_in/load inputs of a downstream parallel-load register directly.
//
// Parameters
//   WIDTH      data bits per frame (2..16)
//   MSB_FIRST  1: first received bit ends up in data_o[WIDTH-1] (shift left)
//              0: first received bit ends up in data_o[0]       (shift right)
//
// Build option
//   PARITY_CHECK_EN  when defined, each frame carries one extra bit after the
//                    data bits, and the frame must have even parity over data
//                    and parity bit. A frame that fails the check is dropped
//                    and parity_err_o pulses. When undefined, parity_err_o is
//                    tied low.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ser_in_i     serial data bit
//   ser_valid_i  ser_in_i / ser_start_i valid this cycle
//   ser_start_i  first bit of a frame (qualified by ser_valid_i)
//   ser_ready_o  a bit is accepted this cycle if ser_valid_i is also high
//   data_o       assembled word, registered, held between loads
//   load_o       one-cycle strobe: data_o holds a new complete word
//   busy_o       frame in progress
//   frame_err_o  one-cycle pulse: partial frame aborted by a new start flag
//   parity_err_o one-cycle pulse: parity failure
// ---------------------------------------------------------------------------
module sipo_frame_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in_i,
  input  logic             ser_valid_i,
  input  logic             ser_start_i,
  output logic             ser_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             load_o,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             parity_err_o
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   data_q;
  logic               load_q;
  logic               frame_err_q;
`ifdef PARITY_CHECK_EN
  logic               parity_err_q;
`endif

  logic               accept;
  logic [WIDTH-1:0]   shift_d;   // shift register with the incoming bit appended
  logic [WIDTH-1:0]   first_d;   // fresh frame holding only the incoming bit

  // Insert one bit at the end dictated by the bit order. After WIDTH inserts
  // the first bit has travelled to the opposite end of the word.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // DONE is the only cycle in which the block refuses data; it is the cycle
  // the completed word is copied to the output register.
  assign ser_ready_o = (state_q != ST_DONE);
  assign accept      = ser_valid_i && ser_ready_o;
  assign shift_d     = shift_in(shift_q, ser_in_i);
  assign first_d     = shift_in('0, ser_in_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      load_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif

      case (state_q)
        ST_IDLE: begin
          // Bits arriving without a start flag are silently dropped.
          if (accept && ser_start_i) begin
            shift_q <= first_d;
            cnt_q   <= CNT_ONE;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (accept) begin
            if (ser_start_i) begin
              // A start flag inside a frame abandons the partial word and
              // the flagged bit becomes bit 1 of the new frame.
              frame_err_q <= 1'b1;
              shift_q     <= first_d;
              cnt_q       <= CNT_ONE;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CNT_ONE;
              if (cnt_q == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_DONE;
`endif
              end
            end
          end
        end

`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          if (accept) begin
            if (ser_start_i) begin
              frame_err_q <= 1'b1;
              shift_q     <= first_d;
              cnt_q       <= CNT_ONE;
              state_q     <= ST_SHIFT;
            end else if (^{shift_q, ser_in_i} == 1'b0) begin
              state_q <= ST_DONE;
            end else begin
              // Bad parity: drop the word, keep the previous output.
              parity_err_q <= 1'b1;
              cnt_q        <= '0;
              state_q      <= ST_IDLE;
            end
          end
        end
`endif

        ST_DONE: begin
          // Word and strobe are registered together so the downstream
          // register sees a complete word in the same cycle as load.
          data_q  <= shift_q;
          load_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign load_o      = load_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_err_o = frame_err_q;
`ifdef PARITY_CHECK_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_deser.sv
// ---------------------------------------------------------------------------
// Directed bench for sipo_frame_deser. Two instances share one serial stream:
// ua uses MSB_FIRST=1, ub uses MSB_FIRST=0, so every frame checks both bit
// orders. Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sipo_frame_deser;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         sin;
  logic         valid;
  logic         start;

  logic         rdy_a, load_a, busy_a, ferr_a, perr_a;
  logic [W-1:0] data_a;
  logic         rdy_b, load_b, busy_b, ferr_b, perr_b;
  logic [W-1:0] data_b;

  int total = 0;
  int bad   = 0;

  sipo_frame_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) ua (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_in_i     (sin),
    .ser_valid_i  (valid),
    .ser_start_i  (start),
    .ser_ready_o  (rdy_a),
    .data_o       (data_a),
    .load_o       (load_a),
    .busy_o       (busy_a),
    .frame_err_o  (ferr_a),
    .parity_err_o (perr_a)
  );

  sipo_frame_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) ub (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_in_i     (sin),
    .ser_valid_i  (valid),
    .ser_start_i  (start),
    .ser_ready_o  (rdy_b),
    .data_o       (data_b),
    .load_o       (load_b),
    .busy_o       (busy_b),
    .frame_err_o  (ferr_b),
    .parity_err_o (perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one input set, let one rising edge consume it, sample after it.
  task automatic step(input logic v, input logic s, input logic b);
    valid = v;
    start = s;
    sin   = b;
    @(posedge clk);
    #1;
  endtask

  // Parity bit slot: only present when the design is built with the check.
  task automatic par_bit(input logic p);
`ifdef PARITY_CHECK_EN
    step(1'b1, 1'b0, p);
`else
    if (p === 1'bx) $display("unused parity value");
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    start = 1'b0;
    sin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- reset state
    chk4("rst_data_a", data_a, 4'b0000);
    chk4("rst_data_b", data_b, 4'b0000);
    chk1("rst_load",   load_a, 1'b0);
    chk1("rst_busy",   busy_a, 1'b0);
    chk1("rst_ferr",   ferr_a, 1'b0);
    chk1("rst_perr",   perr_a, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk1("rst_ready", rdy_a, 1'b1);

    // ---- frame 1,0,1,1 back to back
    step(1'b1, 1'b1, 1'b1);
    chk1("f1_busy_after_start", busy_a, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    par_bit(1'b1);
    // DONE cycle: not ready, no load yet
    chk1("f1_ready_done", rdy_a, 1'b0);
    chk1("f1_load_early", load_a, 1'b0);
    chk1("f1_busy_done",  busy_a, 1'b1);
    // Offer a start bit during DONE; it must be ignored.
    step(1'b1, 1'b1, 1'b0);
    chk1("f1_load",     load_a, 1'b1);
    chk1("f1_load_b",   load_b, 1'b1);
    chk4("f1_data_msb", data_a, 4'b1011);
    chk4("f1_data_lsb", data_b, 4'b1101);
    chk1("f1_ready_after", rdy_a, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk1("f1_load_once",   load_a, 1'b0);
    chk1("f1_done_ignored", busy_a, 1'b0);
    chk4("f1_data_held",   data_a, 4'b1011);

    // ---- frame 1,0,0,0 with a 3-cycle gap after bit 2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk1("f2_busy_gap",  busy_a, 1'b1);
    chk1("f2_load_gap",  load_a, 1'b0);
    chk4("f2_data_gap",  data_a, 4'b1011);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    par_bit(1'b1);
    chk1("f2_load_early", load_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("f2_load",     load_a, 1'b1);
    chk4("f2_data_msb", data_a, 4'b1000);
    chk4("f2_data_lsb", data_b, 4'b0001);
    step(1'b0, 1'b0, 1'b0);
    chk1("f2_load_once", load_b, 1'b0);

    // ---- partial frame 1,1 aborted by new frame 0,1,1,0
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("f3_ferr_none", ferr_a, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk1("f3_ferr",   ferr_a, 1'b1);
    chk1("f3_ferr_b", ferr_b, 1'b1);
    chk1("f3_busy",   busy_a, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("f3_ferr_pulse", ferr_a, 1'b0);
    chk1("f3_no_load_a",  load_a, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk1("f3_no_load_b",  load_a, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    par_bit(1'b0);
    chk1("f3_no_load_c",  load_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("f3_load",     load_a, 1'b1);
    chk4("f3_data_msb", data_a, 4'b0110);
    chk4("f3_data_lsb", data_b, 4'b0110);
    step(1'b0, 1'b0, 1'b0);
    chk1("f3_load_once", load_a, 1'b0);

    // ---- reset after bit 3 of a frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    start = 1'b0;
    sin   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk4("f4_rst_data", data_a, 4'b0000);
    chk1("f4_rst_busy", busy_a, 1'b0);
    chk1("f4_rst_load", load_a, 1'b0);
    chk1("f4_rst_ferr", ferr_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk1("f4_no_load_after", load_a, 1'b0);
    chk1("f4_idle", busy_a, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    par_bit(1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("f4_load",     load_a, 1'b1);
    chk4("f4_data_msb", data_a, 4'b1111);
    chk4("f4_data_lsb", data_b, 4'b1111);
    step(1'b0, 1'b0, 1'b0);

    // ---- bits without start while idle are dropped
    step(1'b1, 1'b0, 1'b0);
    chk1("f5_busy_a", busy_a, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk1("f5_busy_b", busy_a, 1'b0);
    chk1("f5_load_a", load_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("f5_load_b", load_a, 1'b0);
    chk1("f5_ferr",   ferr_a, 1'b0);
    chk4("f5_data",   data_a, 4'b1111);
    chk1("f5_perr",   perr_a, 1'b0);

`ifdef PARITY_CHECK_EN
    // ---- good parity: 1,0,1,1 + 1
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("p1_ready_par", rdy_a, 1'b1);
    chk1("p1_busy_par",  busy_a, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk1("p1_load_early", load_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("p1_load", load_a, 1'b1);
    chk4("p1_data", data_a, 4'b1011);
    chk1("p1_perr", perr_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // ---- bad parity: 1,0,1,1 + 0
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk1("p2_perr",    perr_a, 1'b1);
    chk1("p2_load_a",  load_a, 1'b0);
    chk1("p2_busy",    busy_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("p2_perr_pulse", perr_a, 1'b0);
    chk1("p2_load_b",     load_a, 1'b0);
    chk4("p2_data_held",  data_a, 4'b1011);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
